// File: rtl/v_vram_pkg.sv
// Shared types and constants for the two-port VRAM arbiter.
package v_vram_pkg;

  localparam int unsigned VRAM_AW_DFLT = 64;
  localparam int unsigned VRAM_DW_DFLT = 512;

  localparam logic VPORT_CORE = 1'b0;
  localparam logic VPORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                    we;
    logic                    lock;
    logic [VRAM_AW_DFLT-1:0] addr;
    logic [VRAM_DW_DFLT-1:0] wdata;
    logic [VRAM_DW_DFLT-1:0] wmask;
  } arb_req_t;

endpackage

// File: rtl/v_vram_arbiter_if.sv
// Requester-side bundle for both arbiter ports (index 0 = core, 1 = DMA).
interface v_vram_arbiter_if
  import v_vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW_DFLT,
  parameter int unsigned DW = VRAM_DW_DFLT
);
  logic [1:0]    req_i;
  logic [1:0]    we_i;
  logic [1:0]    lock_i;
  logic [AW-1:0] addr_i  [2];
  logic [DW-1:0] wdata_i [2];
  logic [DW-1:0] wmask_i [2];
  logic [1:0]    gnt_o;
  logic [1:0]    rvalid_o;
  logic [DW-1:0] rdata_o [2];

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i, wmask_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i, wmask_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/v_vram_rd_tag_pipe.sv
// Delay line of {valid, port} tags matching the VRAM read latency.
module v_vram_rd_tag_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic push_valid,
  input  logic push_port,
  output logic out_valid,
  output logic out_port
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] prt;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      prt <= '0;
    end else begin
      vld[0] <= push_valid;
      prt[0] <= push_port;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        prt[i] <= prt[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_port  = prt[DEPTH-1];
endmodule

// File: rtl/v_vram_arbiter.sv
// Round-robin arbiter sharing one VRAM port between the vector core and DMA,
// with burst locking and read-return routing.
module v_vram_arbiter
  import v_vram_pkg::*;
#(
  parameter int unsigned VRAM_AW  = VRAM_AW_DFLT,
  parameter int unsigned VRAM_DW  = VRAM_DW_DFLT,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  v_vram_arbiter_if.slave    bus,
  output logic               vram_r_ena,
  output logic               vram_w_ena,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_w_data,
  output logic [VRAM_DW-1:0] vram_w_mask,
  input  logic [VRAM_DW-1:0] vram_r_data
);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state;
  logic             rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             gnt_any;
  logic             gnt_port;
  logic             lock_port;
  logic             tag_valid;
  logic             tag_port;

  assign lock_port = (state == ST_LOCK1);

  // Grant decision for the current cycle; a lock owner excludes the other port.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = VPORT_CORE;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (bus.req_i == 2'b11) begin
            gnt_any  = 1'b1;
            gnt_port = rr_ptr;
          end else if (bus.req_i[VPORT_CORE]) begin
            gnt_any  = 1'b1;
            gnt_port = VPORT_CORE;
          end else if (bus.req_i[VPORT_DMA]) begin
            gnt_any  = 1'b1;
            gnt_port = VPORT_DMA;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          gnt_any  = bus.req_i[lock_port];
          gnt_port = lock_port;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= VPORT_CORE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            rr_ptr <= ~gnt_port;
            if (bus.lock_i[gnt_port]) begin
              state    <= gnt_port ? ST_LOCK1 : ST_LOCK0;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (gnt_any) begin
            // The LOCK_MAX-th beat releases even if lock is still asserted.
            if (bus.lock_i[gnt_port] && (beat_cnt < CNT_W'(LOCK_MAX - 1))) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end else begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
              rr_ptr   <= ~gnt_port;
            end
          end else if (!bus.lock_i[lock_port]) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o   = {gnt_any & gnt_port, gnt_any & ~gnt_port};
  assign vram_r_ena  = gnt_any & ~bus.we_i[gnt_port];
  assign vram_w_ena  = gnt_any &  bus.we_i[gnt_port];
  assign vram_addr   = gnt_any ? bus.addr_i[gnt_port]  : '0;
  assign vram_w_data = gnt_any ? bus.wdata_i[gnt_port] : '0;
  assign vram_w_mask = gnt_any ? bus.wmask_i[gnt_port] : '0;

  v_vram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .clr        (rst),
    .push_valid (vram_r_ena),
    .push_port  (gnt_port),
    .out_valid  (tag_valid),
    .out_port   (tag_port)
  );

  // Returned data is steered to the tagged port; masked while in reset.
  assign bus.rvalid_o   = {tag_valid & tag_port & ~rst, tag_valid & ~tag_port & ~rst};
  assign bus.rdata_o[0] = bus.rvalid_o[0] ? vram_r_data : '0;
  assign bus.rdata_o[1] = bus.rvalid_o[1] ? vram_r_data : '0;
endmodule
